// File: rtl/br_ram_rd_flow_ctrl.sv
// Read-port front end for a fixed-latency flop RAM: credit-gated request issue,
// in-order response buffering with optional same-cycle bypass of RAM data.
module br_ram_rd_flow_ctrl #(
  parameter int Depth          = 2,
  parameter int Width          = 1,
  parameter int ReadLatency    = 1,
  parameter int RspBufferDepth = 2,
  parameter int EnableBypass   = 1,
  localparam int AddressWidth  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CountWidth    = $clog2(RspBufferDepth + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [AddressWidth-1:0] req_addr,
  output logic                    ram_rd_addr_valid,
  output logic [AddressWidth-1:0] ram_rd_addr,
  input  logic                    ram_rd_data_valid,
  input  logic [Width-1:0]        ram_rd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [Width-1:0]        rsp_data,
  output logic [CountWidth-1:0]   credits,
  output logic                    overflow_err
);

  localparam int PtrWidth = (RspBufferDepth > 1) ? $clog2(RspBufferDepth) : 1;
  localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(RspBufferDepth - 1);
  localparam logic [CountWidth-1:0] FullCount = CountWidth'(RspBufferDepth);

  logic [CountWidth-1:0] credits_q, credits_d;
  logic [CountWidth-1:0] occ_q, occ_d;
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic [Width-1:0]      buf_q [RspBufferDepth];

  logic empty, full, issue, pop, buf_pop, push, bypass_sel;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  // Request path: readiness depends on registered credits only, so no comb loop
  // can form through req_valid.
  assign req_ready         = (credits_q != '0);
  assign issue             = req_valid & req_ready;
  assign ram_rd_addr_valid = issue;
  assign ram_rd_addr       = req_addr;

  assign empty      = (occ_q == '0);
  assign full       = (occ_q == FullCount);
  assign bypass_sel = (EnableBypass != 0) && empty;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    rsp_valid = !empty;
    rsp_data  = buf_q[rd_ptr_q];
    if (bypass_sel) begin
      rsp_valid = ram_rd_data_valid;
      rsp_data  = ram_rd_data;
    end
  end

  assign pop     = rsp_valid & rsp_ready;
  assign buf_pop = pop & !empty;
  // A bypassed beat that is not taken this cycle lands in the buffer so it is
  // re-presented unchanged next cycle.
  assign push    = ram_rd_data_valid & !(bypass_sel & rsp_ready) & (!full | buf_pop);

  always_comb begin
    credits_d  = credits_q - CountWidth'(issue) + CountWidth'(pop);
    occ_d      = occ_q + CountWidth'(push) - CountWidth'(buf_pop);
    wr_ptr_d   = push    ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = buf_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    overflow_d = overflow_q | (ram_rd_data_valid & full & !pop);
  end

  // NOTE: all state registers update with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q  <= FullCount;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: buffer storage is deliberately not reset; occupancy and pointers
  // already mark every entry invalid, and unreset storage maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= ram_rd_data;
  end

  assign credits      = credits_q;
  assign overflow_err = overflow_q;

`ifndef SYNTHESIS
  // credits + occupancy = RspBufferDepth - in-flight; RAM data may only return
  // while something is in flight.
  logic [CountWidth:0] committed;
  assign committed = {1'b0, credits_q} + {1'b0, occ_q};

  a_committed_bound: assert property (@(posedge clk) disable iff (!rst_n)
    committed <= (CountWidth+1)'(RspBufferDepth));

  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (req_valid && !req_ready) |=> (req_valid && $stable(req_addr)));

  a_rd_data_expected: assert property (@(posedge clk) disable iff (!rst_n)
    ram_rd_data_valid |->
      (committed < (CountWidth+1)'(RspBufferDepth)) || (ReadLatency == 0 && issue));
`endif

endmodule

// File: tb/tb_br_ram_rd_flow_ctrl.sv
// Directed bench: three configurations of the read flow controller, each fed by
// a small fixed-latency RAM model whose word at address a is 8'hA4 + a.
module tb_br_ram_rd_flow_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- dut a: RL=1, depth 2, bypass ----------------
  logic       a_req_valid, a_req_ready, a_ram_av, a_ram_dv, a_rsp_valid, a_rsp_ready, a_ovf;
  logic [3:0] a_req_addr, a_ram_a;
  logic [7:0] a_ram_d, a_rsp_data;
  logic [1:0] a_credits;

  br_ram_rd_flow_ctrl #(.Depth(16), .Width(8), .ReadLatency(1), .RspBufferDepth(2), .EnableBypass(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .ram_rd_addr_valid(a_ram_av), .ram_rd_addr(a_ram_a),
    .ram_rd_data_valid(a_ram_dv), .ram_rd_data(a_ram_d),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .credits(a_credits), .overflow_err(a_ovf));

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin a_ram_dv <= 1'b0; a_ram_d <= '0; end
    else begin a_ram_dv <= a_ram_av; a_ram_d <= 8'hA4 + {4'h0, a_ram_a}; end

  // ---------------- dut b: RL=2, depth 3, bypass ----------------
  logic       b_req_valid, b_req_ready, b_ram_av, b_ram_dv, b_rsp_valid, b_rsp_ready, b_ovf;
  logic [3:0] b_req_addr, b_ram_a;
  logic [7:0] b_ram_d, b_rsp_data, b_p1_d;
  logic       b_p1_v;
  logic [1:0] b_credits;

  br_ram_rd_flow_ctrl #(.Depth(16), .Width(8), .ReadLatency(2), .RspBufferDepth(3), .EnableBypass(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .ram_rd_addr_valid(b_ram_av), .ram_rd_addr(b_ram_a),
    .ram_rd_data_valid(b_ram_dv), .ram_rd_data(b_ram_d),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .credits(b_credits), .overflow_err(b_ovf));

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin b_p1_v <= 1'b0; b_p1_d <= '0; b_ram_dv <= 1'b0; b_ram_d <= '0; end
    else begin
      b_p1_v <= b_ram_av; b_p1_d <= 8'hA4 + {4'h0, b_ram_a};
      b_ram_dv <= b_p1_v; b_ram_d <= b_p1_d;
    end

  // ---------------- dut c: RL=1, depth 2, no bypass ----------------
  logic       c_req_valid, c_req_ready, c_ram_av, c_ram_dv, c_rsp_valid, c_rsp_ready, c_ovf;
  logic [3:0] c_req_addr, c_ram_a;
  logic [7:0] c_ram_d, c_rsp_data;
  logic [1:0] c_credits;

  br_ram_rd_flow_ctrl #(.Depth(16), .Width(8), .ReadLatency(1), .RspBufferDepth(2), .EnableBypass(0)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .req_valid(c_req_valid), .req_ready(c_req_ready), .req_addr(c_req_addr),
    .ram_rd_addr_valid(c_ram_av), .ram_rd_addr(c_ram_a),
    .ram_rd_data_valid(c_ram_dv), .ram_rd_data(c_ram_d),
    .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready), .rsp_data(c_rsp_data),
    .credits(c_credits), .overflow_err(c_ovf));

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin c_ram_dv <= 1'b0; c_ram_d <= '0; end
    else begin c_ram_dv <= c_ram_av; c_ram_d <= 8'hA4 + {4'h0, c_ram_a}; end

  initial begin
    rst_n = 1'b0;
    a_req_valid = 0; a_req_addr = '0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_addr = '0; b_rsp_ready = 0;
    c_req_valid = 0; c_req_addr = '0; c_rsp_ready = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset / idle state
    cyc(); @(negedge clk);
    check("a_rst_credits", a_credits, 2);
    check("a_rst_req_ready", a_req_ready, 1);
    check("a_rst_rsp_valid", a_rsp_valid, 0);
    check("a_rst_ovf", a_ovf, 0);
    check("b_rst_credits", b_credits, 3);
    check("c_rst_credits", c_credits, 2);

    // Single request with same-cycle bypass (dut a)
    cyc(); a_req_valid = 1; a_req_addr = 4'h1; a_rsp_ready = 1;
    @(negedge clk);
    check("a_single_issue", a_ram_av, 1);
    check("a_single_addr", a_ram_a, 4'h1);
    check("a_single_rsp_c0", a_rsp_valid, 0);
    cyc(); a_req_valid = 0;
    @(negedge clk);
    check("a_single_rsp_valid", a_rsp_valid, 1);
    check("a_single_rsp_data", a_rsp_data, 8'hA5);
    check("a_single_credits_c1", a_credits, 1);
    cyc(); @(negedge clk);
    check("a_single_credits_c2", a_credits, 2);
    check("a_single_rsp_c2", a_rsp_valid, 0);

    // Back-to-back streaming, one response per cycle (dut b)
    b_rsp_ready = 1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      b_req_valid = (c < 8);
      b_req_addr  = 4'(c);
      @(negedge clk);
      if (c < 8) check("b_stream_req_ready", b_req_ready, 1);
      if (c >= 2) begin
        check("b_stream_rsp_valid", b_rsp_valid, 1);
        check("b_stream_rsp_data", b_rsp_data, 32'(8'hA4 + 8'(c - 2)));
      end
    end
    cyc(); b_req_valid = 0;
    @(negedge clk);
    check("b_stream_end_credits", b_credits, 3);
    check("b_stream_end_rsp", b_rsp_valid, 0);

    // Credit exhaustion and recovery (dut a, rsp_ready low)
    cyc(); a_rsp_ready = 0; a_req_valid = 1; a_req_addr = 4'h2;
    @(negedge clk); check("a_cr_issue1", a_ram_av, 1);
    cyc(); a_req_addr = 4'h3;
    @(negedge clk);
    check("a_cr_issue2", a_ram_av, 1);
    check("a_cr_credits1", a_credits, 1);
    check("a_cr_bypass_hold", a_rsp_data, 8'hA6);
    cyc(); a_req_addr = 4'h4;
    @(negedge clk);
    check("a_cr_ready0", a_req_ready, 0);
    check("a_cr_credits0", a_credits, 0);
    check("a_cr_no_issue", a_ram_av, 0);
    check("a_cr_held_data", a_rsp_data, 8'hA6);
    cyc(); a_rsp_ready = 1;
    @(negedge clk);
    check("a_cr_pop_data", a_rsp_data, 8'hA6);
    check("a_cr_still_blocked", a_req_ready, 0);
    cyc(); a_rsp_ready = 0;
    @(negedge clk);
    check("a_cr_credits_back", a_credits, 1);
    check("a_cr_issue3", a_ram_av, 1);
    check("a_cr_issue3_addr", a_ram_a, 4'h4);
    check("a_cr_second_data", a_rsp_data, 8'hA7);
    cyc(); a_req_valid = 0; a_rsp_ready = 1;
    @(negedge clk);
    check("a_cr_drain1", a_rsp_data, 8'hA7);
    cyc();
    @(negedge clk);
    check("a_cr_drain2_valid", a_rsp_valid, 1);
    check("a_cr_drain2", a_rsp_data, 8'hA8);
    cyc(); @(negedge clk);
    check("a_cr_end_credits", a_credits, 2);
    check("a_cr_end_rsp", a_rsp_valid, 0);
    check("a_cr_ovf", a_ovf, 0);

    // Push and pop in the same cycle with two buffered (dut b)
    cyc(); b_rsp_ready = 0; b_req_valid = 1; b_req_addr = 4'h1;
    cyc(); b_req_addr = 4'h2;
    cyc(); b_req_addr = 4'h3;
    @(negedge clk); check("b_pp_first", b_rsp_data, 8'hA5);
    cyc(); b_req_valid = 0;
    @(negedge clk);
    check("b_pp_hold_valid", b_rsp_valid, 1);
    check("b_pp_hold_data", b_rsp_data, 8'hA5);
    cyc(); b_rsp_ready = 1;
    @(negedge clk);
    check("b_pp_ram_ret", b_ram_dv, 1);
    check("b_pp_pop_data", b_rsp_data, 8'hA5);
    check("b_pp_credits0", b_credits, 0);
    cyc(); b_rsp_ready = 0;
    @(negedge clk);
    check("b_pp_data2", b_rsp_data, 8'hA6);
    check("b_pp_credits1", b_credits, 1);
    check("b_pp_ovf", b_ovf, 0);
    cyc(); b_rsp_ready = 1;
    @(negedge clk); check("b_pp_drain_a6", b_rsp_data, 8'hA6);
    cyc(); @(negedge clk); check("b_pp_drain_a7", b_rsp_data, 8'hA7);
    cyc(); @(negedge clk);
    check("b_pp_end_rsp", b_rsp_valid, 0);
    check("b_pp_end_credits", b_credits, 3);

    // Registered response path without bypass (dut c)
    cyc(); c_req_valid = 1; c_req_addr = 4'h5; c_rsp_ready = 1;
    cyc(); c_req_valid = 0;
    @(negedge clk);
    check("c_nb_ram_ret", c_ram_dv, 1);
    check("c_nb_not_yet", c_rsp_valid, 0);
    cyc(); @(negedge clk);
    check("c_nb_rsp_valid", c_rsp_valid, 1);
    check("c_nb_rsp_data", c_rsp_data, 8'hA9);
    check("c_nb_credits", c_credits, 1);
    cyc(); @(negedge clk);
    check("c_nb_end_credits", c_credits, 2);
    check("c_nb_end_rsp", c_rsp_valid, 0);

    // Asynchronous reset with two requests in flight (dut b)
    cyc(); b_rsp_ready = 0; b_req_valid = 1; b_req_addr = 4'h0;
    cyc(); b_req_addr = 4'h1;
    cyc(); b_req_valid = 0;
    #1;
    check("b_ar_pre_credits", b_credits, 1);
    check("b_ar_pre_rsp", b_rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("b_ar_credits", b_credits, 3);
    check("b_ar_rsp_valid", b_rsp_valid, 0);
    check("b_ar_req_ready", b_req_ready, 1);
    check("b_ar_ovf", b_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("b_ar_post_credits", b_credits, 3);
    cyc(); @(negedge clk);
    check("b_ar_post_rsp", b_rsp_valid, 0);
    check("b_ar_post_credits2", b_credits, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
